// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin owner of one shared up-counter.
// Each requester holds req high and gets a grant of dur+1 cycles, followed by
// a one-cycle done pulse. Dropping req while granted aborts the interval.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no owner; arbitrate among req starting after last_owner
// RUN    | gnt[owner] high, count steps 0..dur_q
// DONE   | done[owner] high for one cycle, no arbitration
module timer_arbiter #(
    parameter int COUNT_W = 16,
    parameter int N_REQ   = 4,
    localparam int OW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*COUNT_W-1:0]   dur,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic                       busy,
    output logic [OW-1:0]              owner,
    output logic [COUNT_W-1:0]         count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [COUNT_W-1:0] dur_q;
    logic [OW-1:0]      last_owner;
    logic [COUNT_W-1:0] dur_arr [N_REQ];
    logic               win_vld;
    logic [OW-1:0]      win_idx;
    logic [OW-1:0]      cand;

    for (genvar i = 0; i < N_REQ; i++) begin : g_dur
        assign dur_arr[i] = dur[i*COUNT_W +: COUNT_W];
    end

    // Round-robin pick: first requester found scanning from last_owner+1.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = OW'((int'(last_owner) + 1 + k) % N_REQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Sequencer: grant, count out the interval, pulse done, or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            gnt        <= '0;
            done       <= '0;
            busy       <= 1'b0;
            owner      <= '0;
            count      <= '0;
            dur_q      <= '0;
            last_owner <= OW'(N_REQ - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    done  <= '0;
                    count <= '0;
                    if (win_vld) begin
                        gnt        <= N_REQ'(1) << win_idx;
                        owner      <= win_idx;
                        last_owner <= win_idx;
                        dur_q      <= dur_arr[win_idx];
                        busy       <= 1'b1;
                        state      <= S_RUN;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Abort wins over the terminal compare in the same cycle.
                    if (!req[owner]) begin
                        gnt   <= '0;
                        count <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (count == dur_q) begin
                        gnt   <= '0;
                        done  <= N_REQ'(1) << owner;
                        count <= '0;
                        state <= S_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    count <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed scenarios plus a randomized run checked
// against a grant-cycles-remaining reference model.
module tb_timer_arbiter;

    localparam int CW  = 16;
    localparam int NR  = 4;
    localparam int CW4 = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR*CW-1:0] dur;
    logic [NR-1:0]    gnt, done;
    logic             busy;
    logic [1:0]       owner;
    logic [CW-1:0]    count;

    logic [NR-1:0]     req4;
    logic [NR*CW4-1:0] dur4;
    logic [NR-1:0]     gnt4, done4;
    logic              busy4;
    logic [1:0]        owner4;
    logic [CW4-1:0]    count4;

    int n_cmp = 0;
    int n_err = 0;

    logic [26:0] obs, exp_v;
    logic [12:0] obs4, exp4;

    timer_arbiter #(.COUNT_W(CW), .N_REQ(NR)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .dur(dur),
        .gnt(gnt), .done(done), .busy(busy), .owner(owner), .count(count)
    );

    timer_arbiter #(.COUNT_W(CW4), .N_REQ(NR)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .dur(dur4),
        .gnt(gnt4), .done(done4), .busy(busy4), .owner(owner4), .count(count4)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_dur(input int i, input int v);
        dur[i*CW +: CW] = CW'(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        dur   = '0;
        req4  = '0;
        dur4  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        obs = {gnt, done, busy, count, owner};
        n_cmp++;
        if (obs !== 27'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected 0", obs);
        end
        obs4 = {gnt4, done4, busy4, count4};
        n_cmp++;
        if (obs4 !== 13'd0) begin
            n_err++;
            $display("FAIL reset_state4: got %h expected 0", obs4);
        end
        @(negedge clk);
        obs = {gnt, done, busy, count, owner};
        n_cmp++;
        if (obs !== 27'd0) begin
            n_err++;
            $display("FAIL idle_no_req: got %h expected 0", obs);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        set_dur(0, 3);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 4)      exp_v = {4'b0001, 4'b0000, 1'b1, 16'(k - 1), 2'd0};
            else if (k == 5) exp_v = {4'b0000, 4'b0001, 1'b1, 16'd0, 2'd0};
            else             exp_v = {4'b0000, 4'b0000, 1'b0, 16'd0, 2'd0};
            obs = {gnt, done, busy, count, owner};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL single cyc%0d: got %h expected %h", k, obs, exp_v);
            end
            if (k == 5) req = 4'b0000;
        end
    endtask

    task automatic test_zero_dur();
        do_reset();
        req = 4'b0100;
        set_dur(2, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1)      exp_v = {4'b0100, 4'b0000, 1'b1, 16'd0, 2'd2};
            else if (k == 2) exp_v = {4'b0000, 4'b0100, 1'b1, 16'd0, 2'd2};
            else             exp_v = {4'b0000, 4'b0000, 1'b0, 16'd0, 2'd2};
            obs = {gnt, done, busy, count, owner};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL zero_dur cyc%0d: got %h expected %h", k, obs, exp_v);
            end
            if (k == 2) req = 4'b0000;
        end
    endtask

    // req[0] is kept high after its first done, so it must wait behind 1,2,3.
    task automatic test_round_robin();
        int d[NR];
        int order[$];
        int start[$];
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        logic [NR-1:0] prev_g;
        int n_done;
        int gi;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            d[i] = int'($urandom_range(0, 3));
            set_dur(i, d[i]);
        end
        req    = 4'b1111;
        prev_g = '0;
        n_done = 0;
        for (int c = 0; c < 300 && n_done < 5; c++) begin
            @(negedge clk);
            if (gnt != 0 && prev_g == 0) begin
                gi = 0;
                for (int b = 0; b < NR; b++) if (gnt[b]) gi = b;
                order.push_back(gi);
                start.push_back(c);
            end
            if (done != 0) begin
                n_done++;
                gi = 0;
                for (int b = 0; b < NR; b++) if (done[b]) gi = b;
                if (!(gi == 0 && n_done == 1)) req[gi] = 1'b0;
            end
            prev_g = gnt;
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= order.size()) begin
                n_err++;
                $display("FAIL rr_order[%0d]: got none expected %0d", i, exp_ord[i]);
            end else if (order[i] != exp_ord[i]) begin
                n_err++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], exp_ord[i]);
            end
        end
        for (int i = 1; i < start.size() && i < 5; i++) begin
            n_cmp++;
            if (start[i] - start[i-1] != d[exp_ord[i-1]] + 3) begin
                n_err++;
                $display("FAIL rr_gap[%0d]: got %0d expected %0d", i,
                         start[i] - start[i-1], d[exp_ord[i-1]] + 3);
            end
        end
    endtask

    task automatic test_abort();
        bit found;
        do_reset();
        set_dur(1, 10);
        set_dur(3, 2);
        req = 4'b0010;
        @(negedge clk);
        req[3] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (gnt == 4'b0010 && count == 16'd4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL abort_reach: got no count=4 expected count=4 under gnt[1]");
        end
        req[1] = 1'b0;
        @(negedge clk);
        obs   = {gnt, done, busy, count, owner};
        exp_v = {4'b0000, 4'b0000, 1'b0, 16'd0, 2'd1};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL abort_next: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        obs   = {gnt, done, busy, count, owner};
        exp_v = {4'b1000, 4'b0000, 1'b1, 16'd0, 2'd3};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL abort_regrant: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_collision();
        bit found;
        do_reset();
        set_dur(0, 2);
        req   = 4'b0001;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt == 4'b0001 && count == 16'd2) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL collide_reach: got no terminal cycle expected count=2");
        end
        req = 4'b0000;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            obs = {gnt, done, busy, count, owner};
            n_cmp++;
            if (obs !== 27'd0) begin
                n_err++;
                $display("FAIL collide cyc%0d: got %h expected 0", k, obs);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        dur4 = 16'h000F;
        req4 = 4'b0001;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k <= 16)      exp4 = {4'b0001, 4'b0000, 1'b1, 4'(k - 1)};
            else if (k == 17) exp4 = {4'b0000, 4'b0001, 1'b1, 4'd0};
            else              exp4 = 13'd0;
            obs4 = {gnt4, done4, busy4, count4};
            n_cmp++;
            if (obs4 !== exp4) begin
                n_err++;
                $display("FAIL wrap cyc%0d: got %h expected %h", k, obs4, exp4);
            end
            if (k == 17) req4 = 4'b0000;
        end
    endtask

    task automatic test_reset_mid_run();
        bit found;
        do_reset();
        set_dur(2, 5);
        req   = 4'b0100;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt == 4'b0100 && count == 16'd2) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL midrst_reach: got no count=2 expected count=2 under gnt[2]");
        end
        #2 rst_n = 1'b0;
        #1;
        obs = {gnt, done, busy, count, owner};
        n_cmp++;
        if (obs !== 27'd0) begin
            n_err++;
            $display("FAIL midrst_outputs: got %h expected 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        @(negedge clk);
        obs   = {gnt, done, busy, count, owner};
        exp_v = {4'b0001, 4'b0000, 1'b1, 16'd0, 2'd0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL midrst_first: got %h expected %h", obs, exp_v);
        end
    endtask

    // Model tracks grant cycles still to run and a pending done flag.
    task automatic test_random();
        int  m_left, m_el, m_owner, m_last, c;
        bit  m_done, found;
        int  n_print;
        logic [NR-1:0] e_g, e_d;
        do_reset();
        m_left  = 0;
        m_el    = 0;
        m_owner = 0;
        m_last  = NR - 1;
        m_done  = 1'b0;
        n_print = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            e_g   = (m_left > 0) ? (4'(1) << m_owner) : 4'b0000;
            e_d   = m_done ? (4'(1) << m_owner) : 4'b0000;
            exp_v = {e_g, e_d, (m_left > 0) || m_done,
                     (m_left > 0) ? 16'(m_el) : 16'd0, 2'(m_owner)};
            obs   = {gnt, done, busy, count, owner};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                if (n_print < 10) begin
                    n_print++;
                    $display("FAIL random cyc%0d: got %h expected %h", cyc, obs, exp_v);
                end
            end
            if (m_done) req[m_owner] = 1'b0;
            else if (m_left > 0 && $urandom_range(0, 29) == 0) req[m_owner] = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    set_dur(i, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                                           : int'($urandom_range(0, 5)));
                end
            end
            if ($urandom_range(0, 7) == 0)
                set_dur(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
            if (m_left > 0) begin
                if (!req[m_owner]) begin
                    m_left = 0;
                    m_el   = 0;
                end else if (m_left == 1) begin
                    m_left = 0;
                    m_el   = 0;
                    m_done = 1'b1;
                end else begin
                    m_left--;
                    m_el++;
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else begin
                found = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    c = (m_last + 1 + k) % NR;
                    if (!found && req[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                        m_last  = c;
                        m_left  = int'(dur[c*CW +: CW]) + 1;
                        m_el    = 0;
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        dur   = '0;
        req4  = '0;
        dur4  = '0;
        test_reset();
        test_single();
        test_zero_dur();
        test_round_robin();
        test_abort();
        test_collision();
        test_wrap();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
